// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the parametrised VC buffer FIFO.
//   clog2        - constant ceil(log2(n)) used to size pointers and the fill count
//   DEF_BW       - default data width
//   DEF_DEPTH    - default number of entries
//   DEF_AF_LEVEL - default almost-full level for VC buffers (DEPTH-1)
//   DEF_AE_LEVEL - default almost-empty level for VC buffers
package fifo_pkg;

   localparam int DEF_BW       = 6;
   localparam int DEF_DEPTH    = 8;
   localparam int DEF_AF_LEVEL = DEF_DEPTH - 1;
   localparam int DEF_AE_LEVEL = 1;

   // Smallest r with 2**r >= n; returns 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port register array for the FIFO.
//   clk      - clock, rising edge
//   reset    - asynchronous active-high reset (read register only; array is not reset)
//   wr_en    - write strobe, writes wr_data to wr_addr at the clock edge
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - read strobe, loads rd_data from rd_addr at the clock edge
//   rd_addr  - read address
//   rd_data  - registered read data, holds its value when rd_en is low
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int BW     = DEF_BW,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BW-1:0]     wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [BW-1:0]     rd_data
);

   logic [BW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // ---- stage p1: registered read port ----
   // A word written at the same edge is not visible here until the next edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO for the per-VC buffer.
//   clk               - clock, rising edge
//   reset             - asynchronous active-high reset
//   fifo_wr           - write request, fifo_data_in - write data
//   fifo_rd           - read request
//   af_level/ae_level - almost-full / almost-empty thresholds
//   err_clr           - clears the sticky overrun/underrun flags
//   fifo_data_out     - registered read data, fifo_data_valid - popped last cycle
//   fifo_fill         - occupancy; fifo_full/fifo_empty/fifo_almost_* - level flags
//   overrun/underrun  - sticky rejected write/read, error_output - either flag
module fifo_param
   import fifo_pkg::*;
#(
   parameter int BW     = DEF_BW,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = clog2(DEPTH),
   parameter int CNT_W  = clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             fifo_wr,
   input  logic [BW-1:0]    fifo_data_in,
   input  logic             fifo_rd,
   input  logic [CNT_W-1:0] af_level,
   input  logic [CNT_W-1:0] ae_level,
   input  logic             err_clr,
   output logic [BW-1:0]    fifo_data_out,
   output logic             fifo_data_valid,
   output logic [CNT_W-1:0] fifo_fill,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic             fifo_almost_full,
   output logic             fifo_almost_empty,
   output logic             overrun,
   output logic             underrun,
   output logic             error_output
);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  fill;
   logic              rd_ok;
   logic              wr_ok;
   logic              rd_vld_p1;

   // DEPTH need not be a power of two, so the wrap is an explicit compare.
   function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
      return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
   endfunction

   // ---- stage p0: acceptance and flags from registered fill ----
   assign fifo_full         = (fill == CNT_W'(DEPTH));
   assign fifo_empty        = (fill == '0);
   assign fifo_almost_full  = (fill >= af_level);
   assign fifo_almost_empty = (fill <= ae_level);
   assign fifo_fill         = fill;

   // A write into a full FIFO is still accepted when a read frees a slot at
   // the same edge; a read from an empty FIFO never sees the concurrent write.
   assign rd_ok = fifo_rd & ~fifo_empty;
   assign wr_ok = fifo_wr & (~fifo_full | fifo_rd);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill      <= '0;
         rd_vld_p1 <= 1'b0;
         overrun   <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (rd_ok) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         if (wr_ok && !rd_ok) begin
            fill <= fill + CNT_W'(1);
         end else if (rd_ok && !wr_ok) begin
            fill <= fill - CNT_W'(1);
         end
         rd_vld_p1 <= rd_ok;
         // New errors take priority over a same-cycle clear.
         overrun  <= (fifo_wr & ~wr_ok) | (overrun  & ~err_clr);
         underrun <= (fifo_rd & ~rd_ok) | (underrun & ~err_clr);
      end
   end

   fifo_mem #(
      .BW     (BW),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_ok),
      .wr_addr (wr_ptr),
      .wr_data (fifo_data_in),
      .rd_en   (rd_ok),
      .rd_addr (rd_ptr),
      .rd_data (fifo_data_out)
   );

   // ---- stage p1: read data and valid ----
   assign fifo_data_valid = rd_vld_p1;
   assign error_output    = overrun | underrun;

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

   localparam int BW    = 6;
   localparam int DEPTH = 8;
   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic             fifo_wr;
   logic [BW-1:0]    fifo_data_in;
   logic             fifo_rd;
   logic [CNT_W-1:0] af_level;
   logic [CNT_W-1:0] ae_level;
   logic             err_clr;
   logic [BW-1:0]    fifo_data_out;
   logic             fifo_data_valid;
   logic [CNT_W-1:0] fifo_fill;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_almost_full;
   logic             fifo_almost_empty;
   logic             overrun;
   logic             underrun;
   logic             error_output;

   int n_tests = 0;
   int n_fail  = 0;

   fifo_param #(.BW(BW), .DEPTH(DEPTH)) dut (
      .clk               (clk),
      .reset             (reset),
      .fifo_wr           (fifo_wr),
      .fifo_data_in      (fifo_data_in),
      .fifo_rd           (fifo_rd),
      .af_level          (af_level),
      .ae_level          (ae_level),
      .err_clr           (err_clr),
      .fifo_data_out     (fifo_data_out),
      .fifo_data_valid   (fifo_data_valid),
      .fifo_fill         (fifo_fill),
      .fifo_full         (fifo_full),
      .fifo_empty        (fifo_empty),
      .fifo_almost_full  (fifo_almost_full),
      .fifo_almost_empty (fifo_almost_empty),
      .overrun           (overrun),
      .underrun          (underrun),
      .error_output      (error_output)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural reference: a queue of words plus the sticky flags.
   int          q[$];
   logic [BW-1:0] m_dout;
   bit          m_vld, m_ovr, m_unr;

   always @(posedge clk or posedge reset) begin
      bit r_ok, w_ok;
      if (reset) begin
         q.delete();
         m_dout = '0;
         m_vld  = 1'b0;
         m_ovr  = 1'b0;
         m_unr  = 1'b0;
      end else begin
         r_ok = fifo_rd && (q.size() > 0);
         w_ok = fifo_wr && ((q.size() < DEPTH) || fifo_rd);
         m_ovr = (fifo_wr && !w_ok) || (m_ovr && !err_clr);
         m_unr = (fifo_rd && !r_ok) || (m_unr && !err_clr);
         m_vld = r_ok;
         if (r_ok) m_dout = BW'(q.pop_front());
         if (w_ok) q.push_back(int'(fifo_data_in));
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the reference.
   always @(negedge clk) begin
      int f;
      f = q.size();
      chk("fill",     int'(fifo_fill), f);
      chk("full",     int'(fifo_full), int'(f == DEPTH));
      chk("empty",    int'(fifo_empty), int'(f == 0));
      chk("afull",    int'(fifo_almost_full), int'(f >= int'(af_level)));
      chk("aempty",   int'(fifo_almost_empty), int'(f <= int'(ae_level)));
      chk("dout",     int'(fifo_data_out), int'(m_dout));
      chk("dvalid",   int'(fifo_data_valid), int'(m_vld));
      chk("overrun",  int'(overrun), int'(m_ovr));
      chk("underrun", int'(underrun), int'(m_unr));
      chk("error",    int'(error_output), int'(m_ovr | m_unr));
   end

   // Hold the inputs across one rising edge; returns at the following falling edge.
   task automatic cyc(input logic w, input logic [BW-1:0] d, input logic r, input logic c);
      fifo_wr      = w;
      fifo_data_in = d;
      fifo_rd      = r;
      err_clr      = c;
      @(negedge clk);
   endtask

   initial begin
      reset        = 1'b1;
      fifo_wr      = 1'b0;
      fifo_data_in = '0;
      fifo_rd      = 1'b0;
      err_clr      = 1'b0;
      af_level     = 4'd6;
      ae_level     = 4'd1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_fill",  int'(fifo_fill), 0);
      chk("rst_empty", int'(fifo_empty), 1);
      chk("rst_full",  int'(fifo_full), 0);
      chk("rst_dv",    int'(fifo_data_valid), 0);
      chk("rst_dout",  int'(fifo_data_out), 0);
      @(negedge clk);

      // Fill 0x01..0x08
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, BW'(i), 1'b0, 1'b0);
         chk("wr_fill", int'(fifo_fill), i);
         chk("wr_afull", int'(fifo_almost_full), int'(i >= 6));
      end
      chk("full8", int'(fifo_full), 1);
      chk("noerr", int'(error_output), 0);

      // Overrun and clear
      cyc(1'b1, 6'h3F, 1'b0, 1'b0);
      chk("ovr_set",  int'(overrun), 1);
      chk("ovr_fill", int'(fifo_fill), 8);
      chk("ovr_err",  int'(error_output), 1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      chk("ovr_clr", int'(overrun), 0);

      // Drain and underrun
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         chk("rd_dout", int'(fifo_data_out), i);
         chk("rd_dv",   int'(fifo_data_valid), 1);
      end
      chk("drain_empty", int'(fifo_empty), 1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("unr_set",  int'(underrun), 1);
      chk("unr_dv",   int'(fifo_data_valid), 0);
      chk("unr_dout", int'(fifo_data_out), 8);
      cyc(1'b0, '0, 1'b0, 1'b1);

      // Pointer wrap-around
      for (int i = 0; i < 5; i++) cyc(1'b1, BW'(16 + i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         chk("wrapA", int'(fifo_data_out), 16 + i);
      end
      for (int i = 0; i < 8; i++) cyc(1'b1, BW'(32 + i), 1'b0, 1'b0);
      chk("wrap_full", int'(fifo_full), 1);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         chk("wrapB", int'(fifo_data_out), 32 + i);
      end
      chk("wrap_fill", int'(fifo_fill), 0);

      // Simultaneous read/write at full
      for (int i = 0; i < 8; i++) cyc(1'b1, BW'(48 + i), 1'b0, 1'b0);
      cyc(1'b1, 6'h3A, 1'b1, 1'b0);
      chk("fullrw_fill", int'(fifo_fill), 8);
      chk("fullrw_ovr",  int'(overrun), 0);
      chk("fullrw_dout", int'(fifo_data_out), 48);
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         chk("fullrw_rd", int'(fifo_data_out), (i == 8) ? 58 : 48 + i);
      end

      // Simultaneous read/write at empty
      cyc(1'b1, 6'h15, 1'b1, 1'b0);
      chk("emptyrw_unr",  int'(underrun), 1);
      chk("emptyrw_fill", int'(fifo_fill), 1);
      chk("emptyrw_dv",   int'(fifo_data_valid), 0);
      cyc(1'b0, '0, 1'b1, 1'b1);
      chk("emptyrw_dout", int'(fifo_data_out), 21);
      chk("emptyrw_dv2",  int'(fifo_data_valid), 1);
      chk("emptyrw_clr",  int'(underrun), 0);

      // Level edge cases
      #1;
      af_level = 4'd0;
      ae_level = 4'd8;
      for (int i = 0; i < 3; i++) cyc(1'b1, BW'(i + 1), 1'b0, 1'b0);
      chk("af0",  int'(fifo_almost_full), 1);
      chk("ae8",  int'(fifo_almost_empty), 1);
      #1;
      af_level = 4'd6;
      ae_level = 4'd1;

      // Asynchronous reset mid-stream
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("pre_rst_dv", int'(fifo_data_valid), 1);
      fifo_rd = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("arst_fill",  int'(fifo_fill), 0);
      chk("arst_empty", int'(fifo_empty), 1);
      chk("arst_dv",    int'(fifo_data_valid), 0);
      chk("arst_dout",  int'(fifo_data_out), 0);
      #1 reset = 1'b0;
      @(negedge clk);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("arst_unr", int'(underrun), 1);
      cyc(1'b0, '0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
